// File: rtl/ram_arb_pkg.sv
// Shared types for the tile/sprite RAM port arbiter: grant kinds, FSM states
// and the read-pipeline slot tags.
package ram_arb_pkg;

  typedef enum logic [1:0] {GNT_NONE, GNT_VID, GNT_CPU, GNT_CLR} grant_t;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam int RD_TAG_W = 2;
  typedef logic [RD_TAG_W-1:0] rd_tag_t;

  localparam rd_tag_t TAG_NONE = 2'd0;
  localparam rd_tag_t TAG_VID  = 2'd1;
  localparam rd_tag_t TAG_CPU  = 2'd2;

endpackage

// File: rtl/ram_clear_seq.sv
// Fill-address counter for the post-reset RAM clear; done marks the cycle
// in which the final location is being written.
module ram_clear_seq #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic                  done
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) fill_addr <= '0;
    else if (run) fill_addr <= fill_addr + ADDR_WIDTH'(1);
  end

  assign done = run && (fill_addr == '1);

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between the video scanner (read-only,
// priority) and the CPU, after an optional post-reset fill with CLEAR_VALUE.
//
// state    | meaning
// ST_CLEAR | fill sequencer writes CLEAR_VALUE to every word; requests ignored
// ST_IDLE  | at most one video or CPU grant per cycle
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 11,
  parameter int                    DATA_WIDTH     = 8,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter int                    MAX_VID_STREAK = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_valid,
  output logic [DATA_WIDTH-1:0] vid_q,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam int                  STREAK_W   = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_STREAK);
  localparam state_t              ST_RESET   = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_t                state, state_nxt;
  grant_t                gnt;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic                  fill_run, fill_last;
  logic [STREAK_W-1:0]   streak;
  logic                  cpu_wait_rd, cpu_done, cpu_ok;
  rd_tag_t               tag_s1;
  logic                  cpu_rd_s2;

  assign fill_run = (state == ST_CLEAR);
  assign busy     = (state == ST_CLEAR);

  ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
    .clock     (clock),
    .reset     (reset),
    .run       (fill_run),
    .fill_addr (fill_addr),
    .done      (fill_last)
  );

  // After an ack the CPU must drop cpu_req for a cycle before it can be
  // granted again, so a request held past its ack is never issued twice.
  assign cpu_ok = cpu_req && !cpu_wait_rd && !cpu_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt       = GNT_NONE;
    if (state == ST_CLEAR) begin
      gnt = GNT_CLR;
      if (fill_last) state_nxt = ST_IDLE;
    end else if (cpu_ok && (!vid_req || streak == STREAK_MAX)) begin
      gnt = GNT_CPU;
    end else if (vid_req) begin
      gnt = GNT_VID;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      tag_s1      <= TAG_NONE;
      vid_valid   <= 1'b0;
      cpu_rd_s2   <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      cpu_wait_rd <= 1'b0;
      cpu_done    <= 1'b0;
      streak      <= '0;
    end else begin
      ram_wren <= 1'b0;
      case (gnt)
        GNT_CLR: begin
          ram_address <= fill_addr;
          ram_data    <= CLEAR_VALUE;
          ram_wren    <= 1'b1;
        end
        GNT_VID: ram_address <= vid_addr;
        GNT_CPU: begin
          ram_address <= cpu_addr;
          ram_data    <= cpu_wdata;
          ram_wren    <= cpu_we;
        end
        default: ;
      endcase

      // Read slots are tagged at issue so returning data goes to its owner.
      if (gnt == GNT_VID)                tag_s1 <= TAG_VID;
      else if (gnt == GNT_CPU && !cpu_we) tag_s1 <= TAG_CPU;
      else                               tag_s1 <= TAG_NONE;

      vid_valid <= (tag_s1 == TAG_VID);
      cpu_rd_s2 <= (tag_s1 == TAG_CPU);
      cpu_ack   <= (gnt == GNT_CPU && cpu_we) || cpu_rd_s2;
      if (cpu_rd_s2) cpu_rdata <= ram_q;

      if (gnt == GNT_CPU && !cpu_we) cpu_wait_rd <= 1'b1;
      else if (cpu_rd_s2)            cpu_wait_rd <= 1'b0;

      if ((gnt == GNT_CPU && cpu_we) || cpu_rd_s2) cpu_done <= 1'b1;
      else if (!cpu_req)                          cpu_done <= 1'b0;

      if (!cpu_req || gnt == GNT_CPU)                  streak <= '0;
      else if (gnt == GNT_VID && streak != STREAK_MAX) streak <= streak + STREAK_W'(1);
    end
  end

  // Video data is taken straight from the RAM output during the valid cycle.
  assign vid_q = vid_valid ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural write-first RAM.
module tb_ram_port_arbiter;

  localparam int         AW    = 11;
  localparam int         DEPTH = 1 << AW;
  localparam logic [7:0] CV    = 8'hA5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_valid;
  logic [7:0]    vid_q;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_we = 1'b0;
  logic [7:0]    cpu_wdata = '0;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          busy;
  logic [AW-1:0] ram_address;
  logic [7:0]    ram_data;
  logic          ram_wren;
  logic [7:0]    ram_q = '0;

  ram_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(8), .CLEAR_ON_RESET(1'b1),
    .CLEAR_VALUE(CV), .MAX_VID_STREAK(4)
  ) dut (
    .clock(clock), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_q(vid_q),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .busy(busy),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_wren) begin
      mem[ram_address] <= ram_data;
      ram_q            <= ram_data;
    end else begin
      ram_q <= mem[ram_address];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {logic [7:0] data; int due; bit is_read;} exp_t;
  exp_t vid_sb[$];
  exp_t cpu_sb[$];

  typedef struct {bit is_cpu; bit we; logic [AW-1:0] addr; logic [7:0] wdata; logic [7:0] exp;} vec_t;
  vec_t vecs [12];

  int n_pass = 0, n_total = 0;
  int n_vid_pulse = 0, n_cpu_pulse = 0;
  int fill_next = 0, fill_bad = 0, wr_cnt = 0;
  bit fill_mon = 0, wr_mon = 0, vid_free = 0;
  logic [7:0] vid_free_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (fill_mon && ram_wren) begin
      if (ram_address !== AW'(fill_next) || ram_data !== CV) fill_bad++;
      fill_next++;
    end
    if (wr_mon && ram_wren) wr_cnt++;
    if (!reset) begin
      if (vid_valid) begin
        n_vid_pulse++;
        if (vid_free) check("vid_q_stream", vid_q, vid_free_data);
        else begin
          check("vid_sb_nonempty", vid_sb.size() != 0, 1);
          if (vid_sb.size() != 0) begin
            e = vid_sb.pop_front();
            check("vid_valid_cycle", cyc, e.due);
            check("vid_q", vid_q, e.data);
          end
        end
      end
      if (cpu_ack) begin
        n_cpu_pulse++;
        check("cpu_sb_nonempty", cpu_sb.size() != 0, 1);
        if (cpu_sb.size() != 0) begin
          e = cpu_sb.pop_front();
          check("cpu_ack_cycle", cyc, e.due);
          if (e.is_read) check("cpu_rdata", cpu_rdata, e.data);
        end
      end
    end
  end

  // Called at a negedge with reset high; releases reset and follows the fill.
  task automatic run_fill(input int abort_at, input bit hold_reqs);
    int n, p0;
    @(negedge clock);
    p0 = n_vid_pulse + n_cpu_pulse;
    if (hold_reqs) begin
      vid_req = 1; vid_addr = 11'h010; cpu_req = 1; cpu_we = 1; cpu_addr = 11'h020;
    end
    check("busy_in_reset", busy, 1);
    check("wren_in_reset", ram_wren, 0);
    fill_next = 0; fill_bad = 0; fill_mon = 1;
    reset = 0;
    n = 0;
    while (busy && n < DEPTH + 10) begin
      @(negedge clock);
      n++;
      if (abort_at != 0 && n == abort_at) break;
    end
    vid_req = 0; cpu_req = 0; cpu_we = 0;
    if (abort_at != 0) begin
      #1 reset = 1;
      @(negedge clock);
      fill_mon = 0;
      check("abort_writes_seen", fill_next, abort_at);
      check("abort_fill_bad", fill_bad, 0);
      check("abort_busy", busy, 1);
      check("abort_wren", ram_wren, 0);
    end else begin
      check("busy_cycles", n, DEPTH);
      @(negedge clock);
      @(negedge clock);
      fill_mon = 0;
      check("fill_writes", fill_next, DEPTH);
      check("fill_order_bad", fill_bad, 0);
    end
    check("no_pulse_during_fill", n_vid_pulse + n_cpu_pulse - p0, 0);
  endtask

  task automatic run_cpu(input bit we, input logic [AW-1:0] a, input logic [7:0] wd, input logic [7:0] exp);
    exp_t e;
    cpu_addr = a; cpu_we = we; cpu_wdata = wd; cpu_req = 1;
    e.data = exp; e.is_read = !we; e.due = cyc + (we ? 1 : 3);
    cpu_sb.push_back(e);
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (cpu_ack) break;
    end
    cpu_req = 0;
    @(negedge clock);
    check("cpu_sb_drained", cpu_sb.size(), 0);
  endtask

  task automatic run_vid(input logic [AW-1:0] a, input logic [7:0] exp);
    exp_t e;
    vid_addr = a; vid_req = 1;
    e.data = exp; e.is_read = 1; e.due = cyc + 2;
    vid_sb.push_back(e);
    @(negedge clock);
    vid_req = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (vid_valid) break;
    end
    @(negedge clock);
    check("vid_sb_drained", vid_sb.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int m, p0;
    vecs[0]  = '{0, 0, 11'h000, 8'h00, 8'hA5};
    vecs[1]  = '{0, 0, 11'h7FF, 8'h00, 8'hA5};
    vecs[2]  = '{1, 1, 11'h123, 8'h3C, 8'h00};
    vecs[3]  = '{1, 0, 11'h123, 8'h00, 8'h3C};
    vecs[4]  = '{1, 1, 11'h400, 8'h11, 8'h00};
    vecs[5]  = '{1, 1, 11'h401, 8'h22, 8'h00};
    vecs[6]  = '{0, 0, 11'h400, 8'h00, 8'h11};
    vecs[7]  = '{1, 0, 11'h401, 8'h00, 8'h22};
    vecs[8]  = '{1, 0, 11'h555, 8'h00, 8'hA5};
    vecs[9]  = '{1, 1, 11'h7FF, 8'h5A, 8'h00};
    vecs[10] = '{0, 0, 11'h7FF, 8'h00, 8'h5A};
    vecs[11] = '{0, 0, 11'h123, 8'h00, 8'h3C};

    repeat (2) @(negedge clock);
    check("rst_ram_address", ram_address, 0);
    check("rst_ram_data", ram_data, 0);
    check("rst_ram_wren", ram_wren, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_vid_q", vid_q, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_busy", busy, 1);

    run_fill(0, 1);
    @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_cpu) run_cpu(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      else                run_vid(vecs[i].addr, vecs[i].exp);
    end

    // CPU write then video read of the same address on the next cycle.
    cpu_addr = 11'h300; cpu_we = 1; cpu_wdata = 8'h77; cpu_req = 1;
    e.data = 8'h00; e.is_read = 0; e.due = cyc + 1; cpu_sb.push_back(e);
    @(negedge clock);
    check("hazard_wr_ack", cpu_ack, 1);
    cpu_req = 0; vid_addr = 11'h300; vid_req = 1;
    e.data = 8'h77; e.is_read = 1; e.due = cyc + 2; vid_sb.push_back(e);
    @(negedge clock);
    vid_req = 0;
    repeat (3) @(negedge clock);
    check("hazard_sb_drained", vid_sb.size() + cpu_sb.size(), 0);

    // CPU request held for 10 cycles across a write.
    p0 = n_cpu_pulse;
    cpu_addr = 11'h600; cpu_we = 1; cpu_wdata = 8'h99; cpu_req = 1;
    e.data = 8'h00; e.is_read = 0; e.due = cyc + 1; cpu_sb.push_back(e);
    wr_cnt = 0; wr_mon = 1;
    repeat (10) @(negedge clock);
    cpu_req = 0;
    repeat (3) @(negedge clock);
    wr_mon = 0;
    check("held_write_ram_writes", wr_cnt, 1);
    check("held_write_acks", n_cpu_pulse - p0, 1);
    run_cpu(0, 11'h600, 8'h00, 8'h99);

    // Video held continuously with CPU reads competing: 4 video grants, then CPU.
    vid_addr = 11'h400; cpu_addr = 11'h401; cpu_we = 0;
    vid_free_data = 8'h11; vid_free = 1; vid_req = 1;
    repeat (3) @(negedge clock);
    for (int it = 0; it < 3; it++) begin
      m = cyc;
      cpu_req = 1;
      e.data = 8'h22; e.is_read = 1; e.due = m + 7; cpu_sb.push_back(e);
      for (int k = 1; k <= 8; k++) begin
        @(negedge clock);
        check($sformatf("streak_vid_valid_k%0d", k), vid_valid, (k == 6) ? 0 : 1);
        if (k == 7) cpu_req = 0;
      end
    end
    vid_req = 0;
    repeat (3) @(negedge clock);
    vid_free = 0;
    check("streak_cpu_sb_drained", cpu_sb.size(), 0);

    // Reset with a CPU read in flight: the read must vanish.
    cpu_addr = 11'h401; cpu_we = 0; cpu_req = 1; vid_addr = 11'h400; vid_req = 1;
    e.data = 8'h11; e.is_read = 1; e.due = cyc + 2; vid_sb.push_back(e);
    @(negedge clock);
    vid_req = 0;
    @(negedge clock);
    #1 reset = 1;
    cpu_req = 0;
    repeat (3) @(negedge clock);
    check("reset_drops_cpu_ack", cpu_ack, 0);
    check("reset_vid_sb_drained", vid_sb.size(), 0);

    // Reset again while the fill is writing address 7, then a full fill.
    run_fill(8, 0);
    run_fill(0, 0);
    @(negedge clock);
    run_vid(11'h123, CV);
    run_cpu(0, 11'h400, 8'h00, CV);

    check("final_vid_sb_empty", vid_sb.size(), 0);
    check("final_cpu_sb_empty", cpu_sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
